// File: rtl/vga_timing_driver.sv
// Programmable-mode VGA timing generator with a latency-matched pixel request port.
// Optional macro VGA_TEST_PATTERN_EN adds a pattern_sel input and an 8-bar colour test pattern.
module vga_timing_driver #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int R_W      = 5,
    parameter int G_W      = 6,
    parameter int B_W      = 5,
    parameter int REQ_LAT  = 1
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                          pattern_sel,
`endif
    output logic                          data_req,
    input  logic [R_W+G_W+B_W-1:0]        data,
    output logic                          h_sync,
    output logic                          v_sync,
    output logic                          de,
    output logic [R_W-1:0]                red,
    output logic [G_W-1:0]                green,
    output logic [B_W-1:0]                blue,
    output logic                          frame_start,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y
);

    localparam int H_TOT   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOT   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOT);
    localparam int VW      = $clog2(V_TOT);
    localparam int PXW     = $clog2(H_ACTIVE);
    localparam int PYW     = $clog2(V_ACTIVE);
    localparam int PW      = R_W + G_W + B_W;
    localparam int H_ACT_S = H_SYNC + H_BACK;
    localparam int H_ACT_E = H_ACT_S + H_ACTIVE - 1;
    localparam int V_ACT_S = V_SYNC + V_BACK;
    localparam int V_ACT_E = V_ACT_S + V_ACTIVE - 1;

    localparam logic          H_ON    = H_POL[0];
    localparam logic          V_ON    = V_POL[0];
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ONE   = HW'(1);
    localparam logic [VW-1:0] V_ONE   = VW'(1);
    localparam logic [HW-1:0] H_START = HW'(H_ACT_S);
    localparam logic [VW-1:0] V_START = VW'(V_ACT_S);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic            h_sync_q, h_sync_d;
    logic            v_sync_q, v_sync_d;
    logic            de_q, de_d;
    logic            data_req_q, data_req_d;
    logic            frame_start_q, frame_start_d;
    logic [R_W-1:0]  red_q, red_d;
    logic [G_W-1:0]  green_q, green_d;
    logic [B_W-1:0]  blue_q, blue_d;
    logic [PXW-1:0]  pix_x_q, pix_x_d;
    logic [PYW-1:0]  pix_y_q, pix_y_d;
    logic            pat_q, pat_d;

    logic [31:0]     h_ext_s;
    logic [31:0]     v_ext_s;
    logic [31:0]     h_la_s;
    logic            h_act_s;
    logic            v_act_s;
    logic            req_win_s;

    // Bar colour as {r,g,b} on/off mask: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            3'd7:    m = 3'b000;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Next-state, counter advance and next output values.
    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_sync_d      = ~H_ON;
        v_sync_d      = ~V_ON;
        de_d          = 1'b0;
        data_req_d    = 1'b0;
        frame_start_d = 1'b0;
        red_d         = {R_W{1'b0}};
        green_d       = {G_W{1'b0}};
        blue_d        = {B_W{1'b0}};
        pix_x_d       = {PXW{1'b0}};
        pix_y_d       = {PYW{1'b0}};
        pat_d         = pat_q;

        h_ext_s   = 32'(h_cnt_q);
        v_ext_s   = 32'(v_cnt_q);
        // Requests look REQ_LAT columns ahead so the returned pixel lands on its de cycle.
        h_la_s    = h_ext_s + 32'(REQ_LAT);
        h_act_s   = (h_ext_s >= 32'(H_ACT_S)) && (h_ext_s <= 32'(H_ACT_E));
        v_act_s   = (v_ext_s >= 32'(V_ACT_S)) && (v_ext_s <= 32'(V_ACT_E));
        req_win_s = (h_la_s >= 32'(H_ACT_S)) && (h_la_s <= 32'(H_ACT_E));

        case (state_q)
            ST_IDLE: begin
                h_cnt_d = {HW{1'b0}};
                v_cnt_d = {VW{1'b0}};
                if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                h_sync_d      = (h_ext_s < 32'(H_SYNC)) ? H_ON : ~H_ON;
                v_sync_d      = (v_ext_s < 32'(V_SYNC)) ? V_ON : ~V_ON;
                de_d          = h_act_s && v_act_s;
                frame_start_d = (h_cnt_q == {HW{1'b0}}) && (v_cnt_q == {VW{1'b0}});
`ifdef VGA_TEST_PATTERN_EN
                if (frame_start_d) begin
                    pat_d = pattern_sel;
                end else begin
                    pat_d = pat_q;
                end
`else
                pat_d = 1'b0;
`endif
                data_req_d = v_act_s && req_win_s && !pat_d;

                if (de_d) begin
                    pix_x_d = PXW'(h_cnt_q - H_START);
                    pix_y_d = PYW'(v_cnt_q - V_START);
                    if (pat_d) begin
                        red_d   = {R_W{bar_mask(pix_x_d[PXW-1 -: 3])[2]}};
                        green_d = {G_W{bar_mask(pix_x_d[PXW-1 -: 3])[1]}};
                        blue_d  = {B_W{bar_mask(pix_x_d[PXW-1 -: 3])[0]}};
                    end else begin
                        red_d   = data[PW-1 -: R_W];
                        green_d = data[B_W +: G_W];
                        blue_d  = data[B_W-1:0];
                    end
                end else begin
                    pix_x_d = {PXW{1'b0}};
                    pix_y_d = {PYW{1'b0}};
                end

                // A stop only takes effect on the wrap back to (0,0).
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = {HW{1'b0}};
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = {VW{1'b0}};
                        if (en) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + V_ONE;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + H_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_cnt_d = {HW{1'b0}};
                v_cnt_d = {VW{1'b0}};
            end
        endcase
    end

    // State, counters and all output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= {HW{1'b0}};
            v_cnt_q       <= {VW{1'b0}};
            h_sync_q      <= ~H_ON;
            v_sync_q      <= ~V_ON;
            de_q          <= 1'b0;
            data_req_q    <= 1'b0;
            frame_start_q <= 1'b0;
            red_q         <= {R_W{1'b0}};
            green_q       <= {G_W{1'b0}};
            blue_q        <= {B_W{1'b0}};
            pix_x_q       <= {PXW{1'b0}};
            pix_y_q       <= {PYW{1'b0}};
            pat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            de_q          <= de_d;
            data_req_q    <= data_req_d;
            frame_start_q <= frame_start_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pat_q         <= pat_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign de          = de_q;
    assign data_req    = data_req_q;
    assign frame_start = frame_start_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver: small 14x7 mode, one instance with REQ_LAT=1 and one with REQ_LAT=3.
module tb_vga_timing_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic        hs_w [2];
    logic        vs_w [2];
    logic        de_w [2];
    logic        req_w [2];
    logic        fs_w [2];
    logic [4:0]  red_w [2];
    logic [5:0]  green_w [2];
    logic [4:0]  blue_w [2];
    logic [2:0]  px_w [2];
    logic [1:0]  py_w [2];
    logic [15:0] data_w [2];
`ifdef VGA_TEST_PATTERN_EN
    logic        pat_sel = 1'b0;
`endif

    vga_timing_driver #(
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .REQ_LAT(1)
    ) dut1 (
        .sys_clk(clk), .rst_n(rst_n), .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pat_sel),
`endif
        .data_req(req_w[0]), .data(data_w[0]), .h_sync(hs_w[0]), .v_sync(vs_w[0]),
        .de(de_w[0]), .red(red_w[0]), .green(green_w[0]), .blue(blue_w[0]),
        .frame_start(fs_w[0]), .pix_x(px_w[0]), .pix_y(py_w[0])
    );

    vga_timing_driver #(
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .REQ_LAT(3)
    ) dut3 (
        .sys_clk(clk), .rst_n(rst_n), .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pat_sel),
`endif
        .data_req(req_w[1]), .data(data_w[1]), .h_sync(hs_w[1]), .v_sync(vs_w[1]),
        .de(de_w[1]), .red(red_w[1]), .green(green_w[1]), .blue(blue_w[1]),
        .frame_start(fs_w[1]), .pix_x(px_w[1]), .pix_y(py_w[1])
    );

    typedef struct {
        int         n;      // posedges since reset release with en=1
        logic [4:0] exp;    // {h_sync, v_sync, de, data_req, frame_start} of the REQ_LAT=1 unit
    } vec_t;
    vec_t vt [14];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int win = 0;
    int de_cnt [2], req_cnt [2], first_req [2], first_de [2];
    int hist [2][4];
    int hs_lo [2], vs_lo [2], req_n [2], de_n [2], fs_n [2];

    function automatic logic [15:0] pval(input int n);
        return 16'(n * 2731 + 5);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ctl(input int d);
        return int'({hs_w[d], vs_w[d], de_w[d], req_w[d], fs_w[d]});
    endfunction

    // Pixel source for both units plus per-pixel scoreboard and frame statistics.
    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                de_cnt[d] = 0; req_cnt[d] = 0; first_req[d] = -1; first_de[d] = -1;
                hs_lo[d] = 0; vs_lo[d] = 0; req_n[d] = 0; de_n[d] = 0; fs_n[d] = 0;
                for (int k = 0; k < 4; k++) hist[d][k] = 0;
            end else begin
                if (de_w[d]) begin
                    check($sformatf("rgb_u%0d_p%0d", d, de_cnt[d]),
                          int'({red_w[d], green_w[d], blue_w[d]}), int'(pval(de_cnt[d])));
                    check($sformatf("pix_x_u%0d", d), int'(px_w[d]), de_cnt[d] % 8);
                    check($sformatf("pix_y_u%0d", d), int'(py_w[d]), (de_cnt[d] / 8) % 4);
                    if (first_de[d] < 0) first_de[d] = cyc;
                    de_cnt[d]++;
                end else begin
                    check($sformatf("blank_u%0d", d),
                          int'({red_w[d], green_w[d], blue_w[d], px_w[d], py_w[d]}), 0);
                end
                if (req_w[d] && first_req[d] < 0) first_req[d] = cyc;
                if (win != 0) begin
                    if (!hs_w[d]) hs_lo[d]++;
                    if (!vs_w[d]) vs_lo[d]++;
                    if (req_w[d]) req_n[d]++;
                    if (de_w[d])  de_n[d]++;
                    if (fs_w[d])  fs_n[d]++;
                end
                for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = req_cnt[d];
                if (req_w[d]) req_cnt[d]++;
            end
            data_w[d] = pval(hist[d][(d == 0) ? 0 : 2]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        data_w[0] = 16'd0;
        data_w[1] = 16'd0;
        vt[0]  = '{1,   5'b11000};
        vt[1]  = '{2,   5'b00001};
        vt[2]  = '{3,   5'b00000};
        vt[3]  = '{4,   5'b10000};
        vt[4]  = '{16,  5'b01000};
        vt[5]  = '{20,  5'b11000};
        vt[6]  = '{30,  5'b01000};
        vt[7]  = '{33,  5'b11010};
        vt[8]  = '{34,  5'b11110};
        vt[9]  = '{40,  5'b11110};
        vt[10] = '{41,  5'b11100};
        vt[11] = '{42,  5'b11000};
        vt[12] = '{90,  5'b11000};
        vt[13] = '{100, 5'b00001};

        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ctl_u%0d", d), ctl(d), 24);
            check($sformatf("reset_pix_u%0d", d),
                  int'({red_w[d], green_w[d], blue_w[d], px_w[d], py_w[d]}), 0);
        end

        // First frame: table vectors and whole-frame statistics.
        en = 1'b1;
        rst_n = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            for (int i = 0; i < 14; i++) begin
                if (vt[i].n == n) check($sformatf("vec_n%0d", n), ctl(0), int'(vt[i].exp));
            end
            if (n == 1)  win = 1;
            if (n == 99) win = 0;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("hsync_low_u%0d", d), hs_lo[d], 14);
            check($sformatf("vsync_low_u%0d", d), vs_lo[d], 14);
            check($sformatf("req_per_frame_u%0d", d), req_n[d], 32);
            check($sformatf("de_per_frame_u%0d", d), de_n[d], 32);
            check($sformatf("fs_per_frame_u%0d", d), fs_n[d], 1);
        end
        check("req_lead_lat1", first_de[0] - first_req[0], 1);
        check("req_lead_lat3", first_de[1] - first_req[1], 3);

        // Drop en mid-frame, let the frame finish, idle, then restart.
        for (int n = 101; n <= 256; n++) begin
            tick();
            if (n == 128) en = 1'b0;
            if (n == 184) check("still_running_hs", int'(hs_w[0]), 0);
            if (n >= 198 && n <= 217) begin
                check($sformatf("idle_u0_n%0d", n), ctl(0), 24);
                check($sformatf("idle_u1_n%0d", n), ctl(1), 24);
            end
            if (n == 220) en = 1'b1;
            if (n == 221) check("restart_fs_early", int'(fs_w[0]), 0);
            if (n == 222) check("restart_fs", int'(fs_w[0]), 1);
        end

        // Asynchronous reset in the middle of an active line.
        check("midline_de", int'(de_w[0]), 1);
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async_rst_ctl_u%0d", d), ctl(d), 24);
            check($sformatf("async_rst_pix_u%0d", d),
                  int'({red_w[d], green_w[d], blue_w[d], px_w[d], py_w[d]}), 0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (n == 1)  check("rerun_fs_n1", int'(fs_w[0]), 0);
            if (n == 2)  check("rerun_fs_n2", int'(fs_w[0]), 1);
            if (n == 30) check("rerun_req3_n30", int'(req_w[1]), 0);
            if (n == 31) check("rerun_req3_n31", int'(req_w[1]), 1);
            if (n == 32) check("rerun_req1_n32", int'(req_w[0]), 0);
            if (n == 33) check("rerun_req1_n33", int'(req_w[0]), 1);
            if (n == 34) check("rerun_de_n34", int'(de_w[0]), 1);
        end
        check("rerun_lead_lat1", first_de[0] - first_req[0], 1);
        check("rerun_lead_lat3", first_de[1] - first_req[1], 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
